// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants, byte width and arbiter FSM states
package uart_pkg;
  localparam int CLK_HZ       = 27_000_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = 234;
  localparam int BYTE_W       = 8;
  typedef enum logic {IDLE, OWN} arb_state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr_i
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic          any_o
);
  logic [PW-1:0] idx;
  always_comb begin
    pick_o = '0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (pick_o == '0 && req_i[idx]) pick_o[idx] = 1'b1;
    end
  end
  assign any_o = |req_i;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin sharing of one UART byte transmitter.
// Define UART_ARB_TIMEOUT_EN to force release of an owner stalled for TIMEOUT_CYCLES.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      tx_valid_o,
  output logic [BYTE_W-1:0]         tx_data_o,
  input  logic                      tx_ready_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);
  localparam int PW = $clog2(NUM_REQ);
  if (NUM_REQ < 2 || NUM_REQ > 8) $error("NUM_REQ out of range 2..8");
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) $error("TIMEOUT_CYCLES out of range");
  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q, pick;
  logic [PW-1:0]      owner_q, ptr_q, ptr_d, pick_idx;
  logic [BYTE_W-1:0]  bytes [NUM_REQ];
  logic               any_req, own, xfer, last_xfer, stall_hit;
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (any_req)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bytes[i] = req_data_i[BYTE_W*i +: BYTE_W];
      if (pick[i]) pick_idx = PW'(i);
    end
  end
  // Datapath is purely combinational off the registered owner so reset clears it at once.
  assign own         = state_q == OWN;
  assign tx_valid_o  = own && req_valid_i[owner_q];
  assign tx_data_o   = own ? bytes[owner_q] : '0;
  assign req_ready_o = grant_q & {NUM_REQ{tx_ready_i}};
  assign grant_o     = grant_q;
  assign busy_o      = own;
  assign xfer        = tx_valid_o && tx_ready_i;
  assign last_xfer   = xfer && req_last_i[owner_q];
  assign ptr_d       = owner_q == PW'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] stall_q;
  logic        timeout_q;
  assign stall_hit = own && !xfer && stall_q == 16'(TIMEOUT_CYCLES - 1);
  assign timeout_o = timeout_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= (!own || xfer || stall_hit) ? '0 : stall_q + 1'b1;
      timeout_q <= stall_hit;
    end
  end
`else
  assign stall_hit = 1'b0;
  assign timeout_o = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else if (state_q == IDLE) begin
      if (any_req) begin
        state_q <= OWN;
        grant_q <= pick;
        owner_q <= pick_idx;
      end
    end else if (last_xfer || stall_hit) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= ptr_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests with a per-cycle behavioural model and literal checks
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int TMO = 16;
  logic         clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid_i = '0, req_last_i = '0, req_ready_o, grant_o;
  logic [N*8-1:0] req_data_i = '0;
  logic         tx_valid_o, tx_ready_i = 1'b0, busy_o, timeout_o;
  logic [7:0]   tx_data_o;
  int checks = 0, errors = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .grant_o(grant_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // requester sources: per-requester byte queues of {last,data}
  logic [8:0] mem [N][64];
  int rd [N], wr [N];
  logic [N-1:0] gap = '0;
  logic [7:0] log_d [64];
  int log_g [64];
  int log_n = 0;
  logic [N-1:0] s_grant, s_rdy;
  logic s_busy, s_txv, s_tmo;
  logic [7:0] s_data;

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][wr[i]] = {l, d};
    wr[i]++;
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      e = (rd[i] != wr[i]) ? mem[i][rd[i]] : 9'h0;
      req_valid_i[i] = (rd[i] != wr[i]) && !gap[i];
      req_data_i[i*8 +: 8] = e[7:0];
      req_last_i[i] = e[8];
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) rd[i] = wr[i];
    gap = '0;
    drive();
  endtask

  function automatic int enc(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    logic [N-1:0] hs, fg;
    logic fire;
    logic [7:0] fd;
    @(negedge clk);
    s_grant = grant_o; s_rdy = req_ready_o; s_busy = busy_o;
    s_txv = tx_valid_o; s_tmo = timeout_o; s_data = tx_data_o;
    hs = req_ready_o & req_valid_i; fire = tx_valid_o && tx_ready_i;
    fd = tx_data_o; fg = grant_o;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) if (hs[i]) rd[i]++;
      if (fire) begin
        log_d[log_n] = fd;
        log_g[log_n] = enc(fg);
        log_n++;
      end
    end
    #1 drive();
  endtask

  task automatic wait_idle();
    int c;
    bit done;
    done = 0;
    for (c = 0; c < 300 && !done; c++) begin
      tick();
      done = 1;
      for (int i = 0; i < N; i++) if (rd[i] != wr[i]) done = 0;
      if (s_busy) done = 0;
    end
    chk("idle_wait", done, 1);
  endtask

  task automatic wait_log(input int n);
    for (int c = 0; c < 50 && log_n < n; c++) tick();
    chk("log_wait", log_n >= n, 1);
  endtask

  task automatic chk_log(input int idx, input int g, input logic [7:0] d);
    chk("log_owner", log_g[idx], g);
    chk("log_data", log_d[idx], d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // behavioural model: current owner (-1 idle), rotating priority pointer, stall count
  int m_own = -1, m_ptr = 0, m_stall = 0;
  logic m_tmo = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own = -1; m_ptr = 0; m_stall = 0; m_tmo = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_own < 0) begin
        m_stall = 0;
        for (int k = 0; k < N; k++)
          if (m_own < 0 && req_valid_i[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
      end else if (req_valid_i[m_own] && tx_ready_i) begin
        m_stall = 0;
        if (req_last_i[m_own]) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
        end
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
        m_stall++;
        if (m_stall == TMO) begin
          m_ptr = (m_own + 1) % N;
          m_own = -1;
          m_tmo = 1'b1;
          m_stall = 0;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg, er;
    logic ev;
    if (!rst) begin
      eg = (m_own < 0) ? '0 : N'(1) << m_own;
      ev = (m_own >= 0) && req_valid_i[m_own];
      er = (m_own < 0) ? '0 : N'(tx_ready_i) << m_own;
      chk("cyc_grant", grant_o, eg);
      chk("cyc_busy", busy_o, m_own >= 0);
      chk("cyc_txv", tx_valid_o, ev);
      chk("cyc_ready", req_ready_o, er);
      chk("cyc_timeout", timeout_o, m_tmo);
      if (m_own < 0) chk("cyc_data", tx_data_o, 8'h00);
      else if (ev) chk("cyc_data", tx_data_o, req_data_i[m_own*8 +: 8]);
    end
  end

  initial begin
    int base, n;
    for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
    #2;
    chk("rst_grant", grant_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_txv", tx_valid_o, 0);
    chk("rst_data", tx_data_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_timeout", timeout_o, 0);
    tick();
    tick();
    rst = 1'b0;
    // single message from requester 0
    tx_ready_i = 1'b1;
    push(0, 8'h48, 0); push(0, 8'h69, 0); push(0, 8'h0D, 1);
    drive();
    tick(); chk("t1_lat_grant", s_grant, 4'b0000);
    tick(); chk("t1_grant", s_grant, 4'b0001); chk("t1_b0", s_data, 8'h48); chk("t1_rdy", s_rdy, 4'b0001);
    tick(); chk("t1_b1", s_data, 8'h69);
    tick(); chk("t1_b2", s_data, 8'h0D); chk("t1_txv", s_txv, 1);
    tick(); chk("t1_idle_busy", s_busy, 0); chk("t1_idle_grant", s_grant, 0);
    wait_idle();
    chk_log(0, 0, 8'h48); chk_log(1, 0, 8'h69); chk_log(2, 0, 8'h0D);
    // fairness: all four requesters, two one-byte messages each
    do_reset();
    base = log_n;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push(i, 8'(16 * i + k), 1);
    drive();
    wait_idle();
    chk("t2_count", log_n - base, 8);
    for (int j = 0; j < 8; j++) chk_log(base + j, j % 4, 8'(16 * (j % 4) + j / 4));
    // backpressure mid-message
    base = log_n;
    for (int j = 0; j < 5; j++) push(2, 8'hA0 + 8'(j), j == 4);
    drive();
    wait_log(base + 2);
    tx_ready_i = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_data", s_data, 8'hA2);
      chk("t3_hold_rdy", s_rdy, 0);
      chk("t3_hold_cnt", log_n, base + 2);
    end
    tx_ready_i = 1'b1;
    wait_idle();
    for (int j = 0; j < 5; j++) chk_log(base + j, 2, 8'hA0 + 8'(j));
    // atomicity: owner 2 gaps while requester 1 waits
    base = log_n;
    for (int j = 0; j < 4; j++) push(2, 8'hB0 + 8'(j), j == 3);
    drive();
    wait_log(base + 1);
    gap[2] = 1'b1;
    push(1, 8'hC0, 1);
    drive();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t4_grant", s_grant, 4'b0100);
      chk("t4_txv", s_txv, 0);
    end
    gap[2] = 1'b0;
    drive();
    wait_idle();
    for (int j = 0; j < 4; j++) chk_log(base + j, 2, 8'hB0 + 8'(j));
    chk_log(base + 4, 1, 8'hC0);
    // asynchronous reset during OWN
    tx_ready_i = 1'b0;
    for (int j = 0; j < 4; j++) push(3, 8'hD0 + 8'(j), j == 3);
    drive();
    for (int c = 0; c < 10 && s_grant != 4'b1000; c++) tick();
    chk("t5_owned", s_grant, 4'b1000);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_grant", grant_o, 0);
    chk("t5_async_busy", busy_o, 0);
    chk("t5_async_txv", tx_valid_o, 0);
    chk("t5_async_rdy", req_ready_o, 0);
    flush();
    tick();
    rst = 1'b0;
    tx_ready_i = 1'b1;
    base = log_n;
    push(0, 8'hE0, 1); push(3, 8'hE3, 1);
    drive();
    wait_idle();
    chk_log(base, 0, 8'hE0); chk_log(base + 1, 3, 8'hE3);
    // stalled owner 1 with requester 2 waiting
    base = log_n;
    push(1, 8'hF0, 0); push(1, 8'hF1, 1);
    drive();
    wait_log(base + 1);
    gap[1] = 1'b1;
    push(2, 8'hF2, 1);
    drive();
`ifdef UART_ARB_TIMEOUT_EN
    n = 0;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      tick();
      if (s_tmo) n = c;
    end
    chk("t6_tmo_latency", n, 17);
    chk("t6_tmo_busy", s_busy, 0);
    tick();
    chk("t6_tmo_pulse", s_tmo, 0);
    chk("t6_next_grant", s_grant, 4'b0100);
`else
    n = 0;
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (s_grant != 4'b0010) n++;
    end
    chk("t6_hold_breaks", n, 0);
    chk("t6_hold_grant", s_grant, 4'b0010);
    chk("t6_no_timeout", s_tmo, 0);
`endif
    gap[1] = 1'b0;
    drive();
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
